// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: datapath width, funct3 codes
// for loads and stores, and the transaction FSM state type.
package lsu_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  // Load funct3 codes
  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StResp = 2'b10,
    StDone = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helpers for the load/store unit.
// Ports:
//   op, we, addr       current instruction funct3, store flag, address low bits
//   wdata              raw store data
//   be, wdata_rep      bus byte enables and lane-replicated store data
//   misalign           misaligned access or illegal funct3
//   ld_op, ld_lane     funct3 and byte lane latched at request time
//   ld_word            raw bus read word
//   ld_data            selected and sign/zero-extended load result
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]           op,
  input  logic                 we,
  input  logic [1:0]           addr,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [3:0]           be,
  output logic [CPU_WIDTH-1:0] wdata_rep,
  output logic                 misalign,
  input  logic [2:0]           ld_op,
  input  logic [1:0]           ld_lane,
  input  logic [CPU_WIDTH-1:0] ld_word,
  output logic [CPU_WIDTH-1:0] ld_data
);

  logic       illegal;
  logic       unaligned;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // Stores only allow SB/SH/SW; loads reject 011, 110 and 111.
    if (we) begin
      illegal = op[2] | (op[1:0] == 2'b11);
    end else begin
      illegal = (op[1:0] == 2'b11) | (op[2] & op[1]);
    end
    case (op[1:0])
      2'b01:   unaligned = addr[0];
      2'b10:   unaligned = |addr;
      default: unaligned = 1'b0;
    endcase
    misalign = illegal | unaligned;
  end

  always_comb begin
    be        = 4'hF;
    wdata_rep = '0;
    if (we) begin
      case (op)
        LSU_SB: begin
          be        = 4'b0001 << addr;
          wdata_rep = {4{wdata[7:0]}};
        end
        LSU_SH: begin
          be        = addr[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        default: begin
          be        = 4'hF;
          wdata_rep = wdata;
        end
      endcase
    end
  end

  // Halfword lanes are always aligned here, so only ld_lane[1] matters.
  assign ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
  assign ld_half = ld_word[{ld_lane[1], 4'b0000} +: 16];

  always_comb begin
    case (ld_op)
      LSU_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LSU_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      LSU_LBU: ld_data = {24'b0, ld_byte};
      LSU_LHU: ld_data = {16'b0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one data-memory transaction per load/store over a
// req/gnt/rvalid bus and stalls the core until it completes.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_req/we/op/addr/wdata   request from the execute stage (held until done)
//   lsu_stall                  hold pc/regfile write
//   lsu_done                   one-cycle completion pulse
//   lsu_rdata/misalign/fault   result, valid with lsu_done, zero otherwise
//   bus_req/we/addr/be/wdata   registered bus request
//   bus_gnt/rvalid/rdata/err   bus handshake and response
module lsu import lsu_pkg::*; #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [2:0]           mem_op,
  input  logic [CPU_WIDTH-1:0] mem_addr,
  input  logic [CPU_WIDTH-1:0] mem_wdata,
  output logic                 lsu_stall,
  output logic                 lsu_done,
  output logic [CPU_WIDTH-1:0] lsu_rdata,
  output logic                 lsu_misalign,
  output logic                 lsu_fault,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [CPU_WIDTH-1:0] bus_addr,
  output logic [3:0]           bus_be,
  output logic [CPU_WIDTH-1:0] bus_wdata,
  input  logic                 bus_gnt,
  input  logic                 bus_rvalid,
  input  logic [CPU_WIDTH-1:0] bus_rdata,
  input  logic                 bus_err
);

  lsu_state_e state_q, state_d;

  logic                 bus_req_q, bus_we_q;
  logic [CPU_WIDTH-1:0] bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]           bus_be_q;
  logic                 misalign_q, fault_q;
  logic [2:0]           op_q;
  logic [1:0]           lane_q;
  logic [31:0]          cnt_q;
  logic                 timeout;

  logic [3:0]           be_nxt;
  logic [CPU_WIDTH-1:0] wdata_nxt, ld_data;
  logic                 misalign;

  lsu_align u_align (
    .op        (mem_op),
    .we        (mem_we),
    .addr      (mem_addr[1:0]),
    .wdata     (mem_wdata),
    .be        (be_nxt),
    .wdata_rep (wdata_nxt),
    .misalign  (misalign),
    .ld_op     (op_q),
    .ld_lane   (lane_q),
    .ld_word   (bus_rdata),
    .ld_data   (ld_data)
  );

  // >= rather than == so a counter that ran past the limit still faults.
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q >= TIMEOUT_CYC - 32'd1);

  always_comb begin
    state_d   = state_q;
    lsu_stall = 1'b0;
    case (state_q)
      StIdle: begin
        lsu_stall = mem_req;
        if (mem_req) state_d = misalign ? StDone : StReq;
      end
      StReq: begin
        lsu_stall = 1'b1;
        if (timeout)      state_d = StDone;
        else if (bus_gnt) state_d = StResp;
      end
      StResp: begin
        lsu_stall = 1'b1;
        if (bus_rvalid || timeout) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
      op_q        <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StReq || state_q == StResp) && cnt_q != '1) begin
        cnt_q <= cnt_q + 32'd1;
      end
      case (state_q)
        StIdle: begin
          if (mem_req) begin
            if (misalign) begin
              misalign_q <= 1'b1;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_we;
              bus_addr_q  <= {mem_addr[CPU_WIDTH-1:2], 2'b00};
              bus_be_q    <= be_nxt;
              bus_wdata_q <= wdata_nxt;
              op_q        <= mem_op;
              lane_q      <= mem_addr[1:0];
              cnt_q       <= '0;
            end
          end
        end
        StReq: begin
          if (timeout) begin
            bus_req_q <= 1'b0;
            fault_q   <= 1'b1;
            rdata_q   <= '0;
          end else if (bus_gnt) begin
            bus_req_q <= 1'b0;
          end
        end
        StResp: begin
          if (bus_rvalid) begin
            fault_q <= bus_err;
            rdata_q <= (bus_err || bus_we_q) ? '0 : ld_data;
          end else if (timeout) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: begin
          // Result registers only hold data during StDone.
          rdata_q    <= '0;
          misalign_q <= 1'b0;
          fault_q    <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_done     = (state_q == StDone);
  assign lsu_rdata    = rdata_q;
  assign lsu_misalign = misalign_q;
  assign lsu_fault    = fault_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_be       = bus_be_q;
  assign bus_wdata    = bus_wdata_q;

endmodule
